// File: rtl/register_pipe.sv
// Elastic WIDTH-bit, DEPTH-stage register pipeline with valid/ready handshaking,
// bubble collapsing, synchronous flush and a registered occupancy count.
module register_pipe #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Handshake: a word moves across a boundary on a clock edge exactly when the
  // sender's valid and the receiver's ready are both high in that cycle; valid
  // never depends on ready, and ready may depend combinationally on downstream ready.

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_rdy;
  logic             w_tail_full;
  logic             w_in_fire;
  logic             w_out_fire;

  // Stage i can accept unless it and every stage after it are occupied and the
  // consumer is stalled; evaluated as a suffix-AND to keep the chain acyclic.
  always_comb begin
    w_rdy       = '0;
    w_tail_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_tail_full = w_tail_full & r_v[i];
      w_rdy[i]    = out_ready | !w_tail_full;
    end
  end

  assign in_ready   = w_rdy[0] & !flush;
  assign out_valid  = r_v[DEPTH-1] & !flush;
  assign out_data   = r_d[DEPTH-1];
  assign count      = r_count;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET_VALUE;
      end
    end else if (flush) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_d[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= r_v[i-1];
          if (r_v[i-1]) begin
            r_d[i] <= r_d[i-1];
          end
        end
      end
      r_count <= r_count + CW'(w_in_fire) - CW'(w_out_fire);
    end
  end

endmodule
